frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter linewidth_px_p, default 161, pixels per image line.
REQ-002 Parameter frame_lines_p, default 120, lines per frame.
REQ-003 Parameter flush_px_p, default 324, zero pixels injected after each frame to drain the cascaded 3x3 line buffers (2*linewidth+2).
REQ-004 Parameter width_p, default 1, pixel width.
REQ-005 clk_i input 1, single clock; all logic rising-edge.
REQ-006 reset_i input 1, synchronous, active-low reset.
REQ-007 ready_o output 1; valid_i input 1; data_i input width_p: pixel stream from the unpacker.
REQ-008 ready_i input 1; valid_o output 1; data_o output width_p: pixel stream to the blur filter.
REQ-009 tail_valid_i input 1; tail_ready_i input 1: monitored handshake at the packer input (observation only).
REQ-010 button_i input 3, raw output-mode select.
REQ-011 mode_o output 3, frame-stable mode select to the output mux.
REQ-012 busy_o output 1, high in any state except IDLE.
REQ-013 frame_done_o output 1, one-cycle pulse at frame completion.

Function
REQ-014 FSM states: IDLE, STREAM, FLUSH, DRAIN.
REQ-015 IDLE: ready_o = ready_i, valid_o = valid_i, data_o = data_i. The first input handshake is counted as pixel 0 and moves the FSM to STREAM.
REQ-016 IDLE, same cycle as that first handshake: mode_o loads the 2-flop-synchronized button_i value.
REQ-017 STREAM: same combinational pass-through. The input counter increments on each valid_i&ready_o handshake.
REQ-018 STREAM: the handshake that makes the count equal linewidth_px_p*frame_lines_p moves the FSM to FLUSH and clears the counter.
REQ-019 FLUSH: ready_o=0, valid_o=1, data_o=0. The counter increments on each ready_i.
REQ-020 FLUSH: the flush_px_p-th accepted zero moves the FSM to DRAIN and clears the counter.
REQ-021 DRAIN: ready_o=0, valid_o=0.
REQ-022 Output counter: independent of the FSM, increments on tail_valid_i&tail_ready_i while busy_o, and clears in IDLE.
REQ-023 When the output count reaches linewidth_px_p*frame_lines_p+flush_px_p in DRAIN: frame_done_o pulses that cycle and the FSM returns to IDLE.
REQ-024 Output count reaching its terminal value while still in FLUSH: the value is held (no wrap), and frame_done_o fires on the first DRAIN cycle.
REQ-025 mode_o SHALL NOT change outside the IDLE-to-STREAM transition. Button changes mid-frame are ignored.
REQ-026 Combinational path: only ready_i->ready_o and valid_i->valid_o, in IDLE/STREAM. No combinational path from tail_* to any output.
REQ-027 Counters are sized $clog2(max terminal count + 1). Comparisons use equality on registered counts.
REQ-028 valid_o stalled by ready_i=0 in FLUSH: valid_o stays 1 and data_o stays 0 (AXIS stability).

Reset
REQ-029 reset_i=0 on a clock edge: state=IDLE, both counters=0, synchronizer flops=0, mode_o=3'b000, frame_done_o=0, busy_o=0.
REQ-030 Reset mid-frame (any state): the same values apply on the next edge. Pixels in flight in the downstream filters are not the block's responsibility.

Structure
REQ-031 A shared package holds: the state enum (frame_state_e), the mode encoding constants (MODE_BLUR=3'b001, MODE_GX=3'b010, MODE_GY=3'b100, default magnitude), and the default IMAGE_W/frame-line constants.
REQ-032 One sub-module, sync2 (2-flop synchronizer, width parameter), is used for button_i.

Verification
Bench parameters: linewidth_px_p=4, frame_lines_p=3, flush_px_p=10.
REQ-033 12 input pixels with ready_i=1 -> data_o mirrors data_i; then 10 zeros on valid_o with ready_o=0.
REQ-034 Tail handshakes continue to a total of 22 -> frame_done_o high exactly one cycle; busy_o falls the next cycle.
REQ-035 button_i=3'b010 before pixel 0, changed to 3'b100 at pixel 5 -> mode_o=3'b010 for the whole frame; next frame -> 3'b100.
REQ-036 ready_i toggled 1/0 every cycle during FLUSH -> exactly 10 zero handshakes, with valid_o held high while stalled.
REQ-037 reset_i=0 at STREAM pixel 7 -> next cycle IDLE, counters 0, mode_o=0; a new frame then completes normally.
REQ-038 All 22 tail handshakes arrive before FLUSH ends -> frame_done_o fires on the first DRAIN cycle; no counter wrap.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the frame sequencer: FSM state encoding,
// output-mode select codes and default image geometry.
package frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DRAIN  = 2'd3
    } frame_state_e;

    // One-hot filter selects; all-zero means gradient magnitude.
    localparam logic [2:0] MODE_MAG  = 3'b000;
    localparam logic [2:0] MODE_BLUR = 3'b001;
    localparam logic [2:0] MODE_GX   = 3'b010;
    localparam logic [2:0] MODE_GY   = 3'b100;

    localparam int IMAGE_W     = 161;
    localparam int FRAME_LINES = 120;
    localparam int FLUSH_PX    = 2 * IMAGE_W + 2;

endpackage

// File: rtl/frame_sequencer_sync2.sv
// Two-flop synchronizer for asynchronous level inputs (button lines).
module sync2 #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] meta_d, meta_q;
    logic [width_p-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: passes one frame of pixels, injects flush zeros to drain
// the 3x3 line buffers, then waits for the packer to consume the whole frame.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int linewidth_px_p = IMAGE_W,
    parameter int frame_lines_p  = FRAME_LINES,
    parameter int flush_px_p     = FLUSH_PX,
    parameter int width_p        = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    // Upstream and downstream pixel streams: a beat moves when valid and
    // ready are both high on a rising edge; valid/data hold while stalled.
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               tail_valid_i,
    input  logic               tail_ready_i,
    input  logic [2:0]         button_i,
    output logic [2:0]         mode_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output frame_state_e       state_o
);

    localparam int FRAME_PX = linewidth_px_p * frame_lines_p;
    localparam int OUT_TERM = FRAME_PX + flush_px_p;
    localparam int IN_MAX   = (FRAME_PX > flush_px_p) ? FRAME_PX : flush_px_p;
    localparam int IN_W     = $clog2(IN_MAX + 1);
    localparam int OUT_W    = $clog2(OUT_TERM + 1);

    localparam logic [IN_W-1:0]  FRAME_LAST = IN_W'(FRAME_PX - 1);
    localparam logic [IN_W-1:0]  FLUSH_LAST = IN_W'(flush_px_p - 1);
    localparam logic [OUT_W-1:0] OUT_DONE   = OUT_W'(OUT_TERM);

    frame_state_e     state_d, state_q;
    logic [IN_W-1:0]  in_cnt_d, in_cnt_q;
    logic [OUT_W-1:0] out_cnt_d, out_cnt_q;
    logic [2:0]       mode_d, mode_q;
    logic [2:0]       button_sync;

    sync2 #(.width_p(3)) u_button_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (button_i),
        .q_o     (button_sync)
    );

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        mode_d       = mode_q;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        data_o       = '0;
        frame_done_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_o = ready_i;
                valid_o = valid_i;
                data_o  = data_i;
                // The first accepted pixel is pixel 0; mode is latched only here.
                if (valid_i && ready_i) begin
                    in_cnt_d = IN_W'(1);
                    mode_d   = button_sync;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ready_o = ready_i;
                valid_o = valid_i;
                data_o  = data_i;
                if (valid_i && ready_i) begin
                    if (in_cnt_q == FRAME_LAST) begin
                        in_cnt_d = '0;
                        state_d  = ST_FLUSH;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    if (in_cnt_q == FLUSH_LAST) begin
                        in_cnt_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_cnt_q == OUT_DONE) begin
                    frame_done_o = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Packer-side count saturates so an early finish still matches in DRAIN.
        if (state_q == ST_IDLE) begin
            out_cnt_d = '0;
        end else if (tail_valid_i && tail_ready_i && (out_cnt_q != OUT_DONE)) begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mode_q    <= MODE_MAG;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            mode_q    <= mode_d;
        end
    end

    assign mode_o  = mode_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;

endmodule
